// File: rtl/mem_fetch_ctrl_pkg.sv
// mem_fetch_ctrl_pkg
// Shared definitions for the image-memory fetch controller: geometry
// defaults, bus widths and the controller state encoding.
package mem_fetch_ctrl_pkg;

  localparam int MAX_ROW_DEF = 540;
  localparam int MAX_COL_DEF = 540;

  localparam int ADDR_W = 19;  // image BRAM address
  localparam int BUF_AW = 11;  // line-buffer address
  localparam int LEN_W  = 20;  // request length / issue / accept counters
  localparam int ROW_W  = 10;  // image row counter
  localparam int PIX_W  = 8;   // pixel width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_fetch_ctrl_skid_fifo2.sv
// skid_fifo2
// Two-entry FIFO between the BRAM read data and the mode-1 pixel stream.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   flush                       synchronous clear of all entries
//   in_valid/in_ready/in_data   write side
//   out_valid/out_ready/out_data read side (head held while stalled)
//   count                       current occupancy 0..2
module skid_fifo2
  import mem_fetch_ctrl_pkg::*;
#(
  parameter int W = PIX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign count     = cnt;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_fetch_ctrl.sv
// mem_fetch_ctrl
// Reads the image BRAM either as a whole-image pixel stream (mode 1) or as
// a fetch of consecutive pixels starting at the current image row into the
// line buffer (mode 2).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   mode1_run_i, fetch_run_i, cnt_len_i request controls and length
//   is_mode2_i                          low clears the row counter
//   bram_en_o, bram_addr_o, bram_rdata_i image BRAM read (1-cycle latency)
//   buf_we_o, buf_addr_o, buf_wdata_o   line-buffer write
//   pix_valid_o, pix_ready_i, pix_data_o mode-1 stream
//   fetch_done_o, mode1_done_o          completion pulses
//   cnt_img_row_o                       current image row
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for a run request
// ST_READ  | issuing BRAM reads
// ST_DRAIN | all reads issued, waiting for last write/transfer
// ST_HOLD  | request finished, waiting for the run input to drop
module mem_fetch_ctrl
  import mem_fetch_ctrl_pkg::*;
#(
  parameter int MAX_ROW = MAX_ROW_DEF,
  parameter int MAX_COL = MAX_COL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode1_run_i,
  input  logic              fetch_run_i,
  input  logic [LEN_W-1:0]  cnt_len_i,
  input  logic              is_mode2_i,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [PIX_W-1:0]  bram_rdata_i,
  output logic              buf_we_o,
  output logic [BUF_AW-1:0] buf_addr_o,
  output logic [PIX_W-1:0]  buf_wdata_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [PIX_W-1:0]  pix_data_o,
  output logic              fetch_done_o,
  output logic              mode1_done_o,
  output logic [ROW_W-1:0]  cnt_img_row_o
);

  state_e            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  accept_cnt;
  logic              mode1_q;
  logic              rd_pend;
  logic              done_q;
  logic [ADDR_W-1:0] row_base;
  logic [ROW_W-1:0]  img_row;

  logic              run_act;
  logic              abort;
  logic              credit;
  logic              issue;
  logic              last_issue;
  logic              wr_fire;
  logic              xfer;
  logic              acc;
  logic              last_acc;
  logic              done_set;
  logic              fifo_push;
  logic              fifo_in_ready;
  logic              fifo_valid;
  logic [PIX_W-1:0]  fifo_data;
  logic [1:0]        fifo_cnt;

  assign run_act = mode1_q ? mode1_run_i : fetch_run_i;
  assign abort   = ((state == ST_READ) || (state == ST_DRAIN)) && !run_act;

  // Mode 1 only issues when the returning word is guaranteed a FIFO slot.
  assign credit     = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !rd_pend);
  assign issue      = (state == ST_READ) && run_act && (issue_cnt < len_q) &&
                      (!mode1_q || credit);
  assign last_issue = issue && (issue_cnt == len_q - 20'd1);

  // Data returning during an abort cycle is dropped.
  assign wr_fire   = rd_pend && !mode1_q && !abort;
  assign fifo_push = rd_pend && mode1_q && !abort && fifo_in_ready;
  assign xfer      = fifo_valid && pix_ready_i;
  assign acc       = mode1_q ? xfer : wr_fire;
  assign last_acc  = acc && (accept_cnt == len_q - 20'd1);
  assign done_set  = !abort && (((state == ST_READ) && (len_q == '0)) ||
                                ((state == ST_DRAIN) && last_acc));

  assign bram_en_o   = issue;
  assign bram_addr_o = !issue ? '0 :
                       mode1_q ? issue_cnt[ADDR_W-1:0] :
                                 row_base + issue_cnt[ADDR_W-1:0];
  assign buf_we_o    = wr_fire;
  assign buf_addr_o  = wr_fire ? accept_cnt[BUF_AW-1:0] : '0;
  assign buf_wdata_o = wr_fire ? bram_rdata_i : '0;
  assign pix_valid_o = fifo_valid;
  assign pix_data_o  = fifo_valid ? fifo_data : '0;
  assign fetch_done_o  = done_q && !mode1_q;
  assign mode1_done_o  = done_q && mode1_q;
  assign cnt_img_row_o = img_row;

  skid_fifo2 #(.W(PIX_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .in_valid  (fifo_push),
    .in_ready  (fifo_in_ready),
    .in_data   (bram_rdata_i),
    .out_valid (fifo_valid),
    .out_ready (pix_ready_i),
    .out_data  (fifo_data),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      mode1_q    <= 1'b0;
      rd_pend    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q  <= done_set;
      rd_pend <= issue;
      if (issue) issue_cnt  <= issue_cnt + 20'd1;
      if (acc)   accept_cnt <= accept_cnt + 20'd1;
      case (state)
        ST_IDLE: begin
          if (mode1_run_i || fetch_run_i) begin
            len_q      <= cnt_len_i;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            mode1_q    <= mode1_run_i;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          if (abort)               state <= ST_IDLE;
          else if (len_q == '0)    state <= ST_HOLD;
          else if (last_issue)     state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (abort)               state <= ST_IDLE;
          else if (last_acc)       state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!run_act)            state <= ST_IDLE;
        end
        default:                   state <= ST_IDLE;
      endcase
    end
  end

  // row_base tracks img_row*MAX_COL incrementally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_row  <= '0;
      row_base <= '0;
    end else if (!is_mode2_i) begin
      img_row  <= '0;
      row_base <= '0;
    end else if (done_set && !mode1_q && (img_row != ROW_W'(MAX_ROW - 1))) begin
      img_row  <= img_row + 10'd1;
      row_base <= row_base + ADDR_W'(MAX_COL);
    end
  end

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
module tb_mem_fetch_ctrl;

  localparam int MAX_ROW = 4;
  localparam int MAX_COL = 540;

  logic        clk;
  logic        rst_n;
  logic        mode1_run_i;
  logic        fetch_run_i;
  logic [19:0] cnt_len_i;
  logic        is_mode2_i;
  logic        bram_en_o;
  logic [18:0] bram_addr_o;
  logic [7:0]  bram_rdata_i;
  logic        buf_we_o;
  logic [10:0] buf_addr_o;
  logic [7:0]  buf_wdata_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic [7:0]  pix_data_o;
  logic        fetch_done_o;
  logic        mode1_done_o;
  logic [9:0]  cnt_img_row_o;

  mem_fetch_ctrl #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode1_run_i   (mode1_run_i),
    .fetch_run_i   (fetch_run_i),
    .cnt_len_i     (cnt_len_i),
    .is_mode2_i    (is_mode2_i),
    .bram_en_o     (bram_en_o),
    .bram_addr_o   (bram_addr_o),
    .bram_rdata_i  (bram_rdata_i),
    .buf_we_o      (buf_we_o),
    .buf_addr_o    (buf_addr_o),
    .buf_wdata_o   (buf_wdata_o),
    .pix_valid_o   (pix_valid_o),
    .pix_ready_i   (pix_ready_i),
    .pix_data_o    (pix_data_o),
    .fetch_done_o  (fetch_done_o),
    .mode1_done_o  (mode1_done_o),
    .cnt_img_row_o (cnt_img_row_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: contents are the low byte of the address, 1-cycle latency.
  always @(posedge clk)
    bram_rdata_i <= bram_en_o ? bram_addr_o[7:0] : 8'($urandom);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model of the current request.
  int  model_row;
  int  exp_base, exp_len, exp_issue, exp_wr, exp_pix;
  int  fd_cnt, m1d_cnt;
  int  last_we_cyc, last_xfer_cyc;
  int  first_addr, last_addr;
  bit  chk_en = 0;
  bit  prev_stall;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n || !chk_en) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("pix_hold_valid", pix_valid_o, 1);
        chk("pix_hold_data", pix_data_o, prev_data);
      end
      if (bram_en_o) begin
        chk("bram_addr", bram_addr_o, exp_base + exp_issue);
        if (exp_issue == 0) first_addr = int'(bram_addr_o);
        last_addr = int'(bram_addr_o);
        exp_issue++;
      end
      if (buf_we_o) begin
        chk("buf_addr", buf_addr_o, exp_wr);
        chk("buf_wdata", buf_wdata_o, (exp_base + exp_wr) % 256);
        exp_wr++;
        last_we_cyc = cyc;
      end
      if (pix_valid_o && pix_ready_i) begin
        chk("pix_data", pix_data_o, exp_pix % 256);
        exp_pix++;
        last_xfer_cyc = cyc;
      end
      if (fetch_done_o) begin
        fd_cnt++;
        chk("fetch_done_writes", exp_wr, exp_len);
        if (exp_len > 0) chk("fetch_done_timing", cyc, last_we_cyc + 1);
      end
      if (mode1_done_o) begin
        m1d_cnt++;
        chk("mode1_done_xfers", exp_pix, exp_len);
        if (exp_len > 0) chk("mode1_done_timing", cyc, last_xfer_cyc + 1);
      end
      prev_stall = pix_valid_o && !pix_ready_i;
      prev_data  = pix_data_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_req(input bit m1, input int len);
    exp_len   = len;
    exp_issue = 0;
    exp_wr    = 0;
    exp_pix   = 0;
    fd_cnt    = 0;
    m1d_cnt   = 0;
    first_addr = -1;
    last_addr  = -1;
    exp_base  = m1 ? 0 : model_row * MAX_COL;
    cnt_len_i = 20'(len);
    if (m1) mode1_run_i = 1'b1;
    else    fetch_run_i = 1'b1;
  endtask

  task automatic wait_done(input bit m1, input int bound);
    int n = 0;
    while (((m1 ? m1d_cnt : fd_cnt) == 0) && (n < bound)) begin
      if (m1) pix_ready_i = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    chk(m1 ? "mode1_done_seen" : "fetch_done_seen", ((m1 ? m1d_cnt : fd_cnt) > 0) ? 1 : 0, 1);
    tick(3);
    chk(m1 ? "mode1_done_once" : "fetch_done_once", m1 ? m1d_cnt : fd_cnt, 1);
  endtask

  task automatic do_fetch(input int len);
    start_req(0, len);
    wait_done(0, len + 20);
    chk("fetch_issues", exp_issue, len);
    chk("fetch_writes", exp_wr, len);
    if (model_row < MAX_ROW - 1) model_row++;
    chk("row_after_fetch", cnt_img_row_o, model_row);
    fetch_run_i = 1'b0;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int snap_i, snap_w, n;
    rst_n = 1'b0;
    mode1_run_i = 1'b0;
    fetch_run_i = 1'b0;
    cnt_len_i = '0;
    is_mode2_i = 1'b1;
    pix_ready_i = 1'b0;
    model_row = 0;
    #23;
    chk("rst_bram_en", bram_en_o, 0);
    chk("rst_bram_addr", bram_addr_o, 0);
    chk("rst_buf_we", buf_we_o, 0);
    chk("rst_buf_addr", buf_addr_o, 0);
    chk("rst_buf_wdata", buf_wdata_o, 0);
    chk("rst_pix_valid", pix_valid_o, 0);
    chk("rst_pix_data", pix_data_o, 0);
    chk("rst_fetch_done", fetch_done_o, 0);
    chk("rst_mode1_done", mode1_done_o, 0);
    chk("rst_row", cnt_img_row_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1;
    tick(2);

    // First fetch from row 0.
    do_fetch(1620);
    chk("f1_row_lit", cnt_img_row_o, 1);
    chk("f1_writes_lit", exp_wr, 1620);
    chk("f1_last_addr_lit", last_addr, 1619);

    // Two more: third reads 1080..2699.
    do_fetch(1620);
    do_fetch(1620);
    chk("f3_first_addr_lit", first_addr, 1080);
    chk("f3_last_addr_lit", last_addr, 2699);
    chk("f3_row_lit", cnt_img_row_o, 3);

    // Row counter saturates at MAX_ROW-1.
    do_fetch(10);
    chk("sat_first_addr_lit", first_addr, 1620);
    chk("sat_row_lit", cnt_img_row_o, 3);

    // is_mode2_i low clears the row counter.
    is_mode2_i = 1'b0;
    tick(1);
    chk("mode2_clear_row", cnt_img_row_o, 0);
    is_mode2_i = 1'b1;
    model_row = 0;
    tick(1);

    // Abort after 100 issues.
    start_req(0, 1620);
    n = 0;
    while (exp_issue < 100 && n < 300) begin tick(1); n++; end
    chk("abort_reached_100", (exp_issue >= 100) ? 1 : 0, 1);
    fetch_run_i = 1'b0;
    snap_i = exp_issue;
    snap_w = exp_wr;
    tick(6);
    chk("abort_no_more_issue", exp_issue, snap_i);
    chk("abort_no_more_write", exp_wr, snap_w);
    chk("abort_no_done", fd_cnt, 0);
    chk("abort_row_kept", cnt_img_row_o, 0);
    do_fetch(20);
    chk("post_abort_first_addr_lit", first_addr, 0);
    chk("post_abort_last_addr_lit", last_addr, 19);
    chk("post_abort_row_lit", cnt_img_row_o, 1);

    // Mode 1 stream, random backpressure.
    start_req(1, 16);
    wait_done(1, 300);
    chk("m1_xfers_lit", exp_pix, 16);
    chk("m1_issues", exp_issue, 16);
    chk("m1_no_buf_write", exp_wr, 0);
    chk("m1_no_fetch_done", fd_cnt, 0);
    chk("m1_row_kept", cnt_img_row_o, 1);
    mode1_run_i = 1'b0;
    pix_ready_i = 1'b0;
    tick(2);

    // Zero-length fetch.
    start_req(0, 0);
    wait_done(0, 3);
    chk("len0_issues", exp_issue, 0);
    chk("len0_writes", exp_wr, 0);
    fetch_run_i = 1'b0;
    tick(2);
    is_mode2_i = 1'b0;
    tick(1);
    chk("len0_mode2_clear_row", cnt_img_row_o, 0);
    is_mode2_i = 1'b1;
    model_row = 0;
    tick(1);

    // Reset in the middle of a stalled mode-1 stream.
    start_req(1, 16);
    pix_ready_i = 1'b0;
    n = 0;
    while (!pix_valid_o && n < 10) begin tick(1); n++; end
    chk("m1r_valid_seen", pix_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("m1r_valid_async_clear", pix_valid_o, 0);
    chk("m1r_data_async_clear", pix_data_o, 0);
    chk("m1r_bram_en_clear", bram_en_o, 0);
    mode1_run_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_row = 0;
    tick(2);
    chk("m1r_no_done", m1d_cnt, 0);
    do_fetch(8);
    chk("m1r_fetch_first_addr_lit", first_addr, 0);
    chk("m1r_fetch_row_lit", cnt_img_row_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_fetch_ctrl.md
MEM_FETCH_CTRL -- requirements
Module: mem_fetch_ctrl

Interface
REQ-001 SHALL have parameter MAX_ROW, default 540, meaning image rows.
REQ-002 SHALL have parameter MAX_COL, default 540, meaning pixels per row (row stride in BRAM).
REQ-003 SHALL have port clk  in  1  the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports mode1_run_i  in  1  whole-image stream request; fetch_run_i  in  1  3-row fetch request.
REQ-006 SHALL have port cnt_len_i  in  20  pixel count for the current request (291600 mode1, 1620 fetch).
REQ-007 SHALL have port is_mode2_i  in  1  mode-2 session active; clears the row counter when low.
REQ-008 SHALL have ports bram_en_o  out  1, bram_addr_o  out  19, bram_rdata_i  in  8  image BRAM read port, data valid 1 cycle after en.
REQ-009 SHALL have ports buf_we_o  out  1, buf_addr_o  out  11, buf_wdata_o  out  8  line-buffer write port (mode 2).
REQ-010 SHALL have ports pix_valid_o  out  1, pix_ready_i  in  1, pix_data_o  out  8  mode-1 output stream.
REQ-011 SHALL have ports fetch_done_o  out  1, mode1_done_o  out  1, cnt_img_row_o  out  10.

Function
REQ-012 SHALL implement FSM states IDLE, READ, DRAIN, HOLD.
REQ-013 IDLE->READ on mode1_run_i or fetch_run_i high; cnt_len_i latched and issue/accept counters cleared that cycle; mode1_run_i wins if both high.
REQ-014 Fetch: READ issues one BRAM read per cycle, addresses row_base..row_base+len-1; row_base = cnt_img_row*MAX_COL, maintained by adding MAX_COL (no multiplier).
REQ-015 Fetch: each returned word written 1 cycle after issue, buf_addr_o 0..len-1 in order, buf_we_o high only for valid data.
REQ-016 Fetch: READ->DRAIN after last issue; DRAIN->HOLD with fetch_done_o one-cycle pulse the cycle after last buf_we_o.
REQ-017 fetch_done_o pulse SHALL increment cnt_img_row_o by 1 in the same edge; cnt_img_row_o saturates at MAX_ROW-1.
REQ-018 Mode 1: addresses 0..len-1; reads pass through a 2-entry skid FIFO to pix_*; a read issues only if FIFO occupancy plus in-flight read < 2.
REQ-019 Mode 1: pixel transfers on pix_valid_o & pix_ready_i; pix_data_o stable while valid & !ready; order = address order.
REQ-020 Mode 1: mode1_done_o one-cycle pulse in the cycle after the len-th transfer; FSM then HOLD.
REQ-021 HOLD: wait until the active run input is low, then IDLE; no new request accepted in HOLD.
REQ-022 Run input dropped in READ/DRAIN: abort to IDLE next cycle, flush FIFO, discard in-flight data, no done pulse, row counter unchanged.
REQ-023 cnt_len_i == 0: READ->HOLD immediately, done pulse next cycle, no BRAM/buffer/stream activity.
REQ-024 is_mode2_i low SHALL clear cnt_img_row_o and row_base synchronously.
REQ-025 Counters: 20-bit issue/accept counters; no wrap inside a request.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, FIFO empty, cnt_img_row_o=0, row_base=0, and all outputs 0.
REQ-027 Reset mid-operation SHALL drop any pending done pulse; first request after release behaves as from power-up.

Structure
REQ-028 FSM state enum, MAX_ROW/MAX_COL defaults, and widths (19 addr, 11 buf addr, 20 len) SHALL live in the shared project package.
REQ-029 The 2-entry skid FIFO SHALL be sub-module skid_fifo2 (8-bit data, valid/ready both sides).

Verification
REQ-030 Fetch len=1620, row 0, BRAM data=addr[7:0] -> buf writes addr 0..1619 data 0..1619 mod 256, one fetch_done_o pulse, cnt_img_row_o=1.
REQ-031 Three consecutive fetches (run dropped between) -> third reads BRAM 1080..2699, cnt_img_row_o=3.
REQ-032 Mode 1 len=16, pix_ready_i random 50% -> 16 in-order pixels 0..15, no duplicates/drops, mode1_done_o once after 16th transfer.
REQ-033 fetch_run_i dropped after 100 issues -> IDLE, no fetch_done_o, cnt_img_row_o unchanged; next fetch writes from buf addr 0.
REQ-034 cnt_len_i=0 fetch -> done pulse within 2 cycles, zero buf_we_o; is_mode2_i low -> cnt_img_row_o=0.
REQ-035 rst_n asserted mid mode-1 stream with pix_valid_o high -> pix_valid_o=0 immediately (asynchronous), state IDLE.
